// File: rtl/crc8_framer_if.sv
// Byte-stream handshake bundle for crc8_framer: input stream plus the registered output stream.
// The master side is the byte source and sink; the slave side is the framer.
interface crc8_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_crc;
    logic       crc_err;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_crc, crc_err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_crc, crc_err
    );
endinterface

// File: rtl/crc8_framer.sv
// CRC-8 stream framer: passes payload bytes, inserts or checks one CRC byte per frame,
// then passes a fixed number of uncovered gap bytes. Single registered output stage.
module crc8_framer #(
    parameter logic [7:0]  POLYNOMIAL  = 8'h07,
    parameter logic [7:0]  INITIAL     = 8'hFF,
    parameter logic [7:0]  XOR_OUT     = 8'h00,
    parameter int unsigned PAYLOAD_LEN = 8,
    parameter int unsigned GAP_LEN     = 1,
    localparam int unsigned CW         = $clog2(PAYLOAD_LEN + GAP_LEN + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode_check,
    crc8_framer_if.slave        bus,
    output logic [CW-1:0]       byte_counter
);

    typedef enum logic [1:0] {StPayload, StCrc, StGap} state_e;

    localparam logic [CW-1:0] PayLast   = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] FrameLast = CW'(PAYLOAD_LEN + GAP_LEN);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      crc_q, crc_d;
    logic            mode_q, mode_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_crc_q, out_crc_d;
    logic            crc_err_q, crc_err_d;

    logic            free;
    logic            gen_crc;
    logic            in_ready;
    logic            produce;
    logic [7:0]      crc_tx;

    function automatic logic [7:0] crc_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        end
        return c;
    endfunction

    // In generate mode the CRC beat needs only a free output slot, no input byte.
    always_comb begin
        free     = !out_valid_q || bus.out_ready;
        gen_crc  = (state_q == StCrc) && !mode_q;
        in_ready = free && !gen_crc;
        produce  = gen_crc ? free : (bus.in_valid && in_ready);
        crc_tx   = crc_q ^ XOR_OUT;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        crc_err_d   = crc_err_q;

        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
            out_crc_d   = 1'b0;
            crc_err_d   = 1'b0;
            cnt_d       = (cnt_q == FrameLast) ? '0 : cnt_q + CW'(1);
            unique case (state_q)
                StPayload: begin
                    // First payload byte latches the mode and restarts the CRC.
                    if (cnt_q == '0) begin
                        mode_d = mode_check;
                        crc_d  = crc_byte(INITIAL, bus.in_data);
                    end else begin
                        crc_d  = crc_byte(crc_q, bus.in_data);
                    end
                    if (cnt_q == PayLast) begin
                        state_d = StCrc;
                    end
                end
                StCrc: begin
                    out_crc_d = 1'b1;
                    if (mode_q) begin
                        crc_err_d = (bus.in_data != crc_tx);
                    end else begin
                        out_data_d = crc_tx;
                    end
                    state_d = (GAP_LEN == 0) ? StPayload : StGap;
                end
                StGap: begin
                    if (cnt_q == FrameLast) begin
                        state_d = StPayload;
                    end
                end
                default: state_d = StPayload;
            endcase
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_crc_d   = 1'b0;
            crc_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StPayload;
            cnt_q       <= '0;
            crc_q       <= INITIAL;
            mode_q      <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_crc_q   <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_crc   = out_crc_q;
    assign bus.crc_err   = crc_err_q;
    assign byte_counter  = cnt_q;

endmodule

// File: tb/tb_crc8_framer.sv
// Directed bench for crc8_framer: three instances cover the reference-string frame,
// the short-frame generate/check cases, and default-parameter backpressure, reset and mode cases.
module tb_crc8_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] drv_data  [3];
    logic       drv_valid [3];
    logic       drv_ready [3];
    logic       drv_mode  [3];

    logic [7:0] o_data  [3];
    logic       o_valid [3];
    logic       o_rdy   [3];
    logic       o_crc   [3];
    logic       o_err   [3];
    logic [7:0] o_bc    [3];

    logic [3:0] bc0;
    logic [1:0] bc1;
    logic [3:0] bc2;

    crc8_framer_if if0 ();
    crc8_framer_if if1 ();
    crc8_framer_if if2 ();

    crc8_framer #(.INITIAL(8'h00), .PAYLOAD_LEN(9), .GAP_LEN(0)) dut0 (
        .clk(clk), .reset(rst_n), .mode_check(drv_mode[0]), .bus(if0), .byte_counter(bc0)
    );
    crc8_framer #(.INITIAL(8'h00), .PAYLOAD_LEN(1), .GAP_LEN(1)) dut1 (
        .clk(clk), .reset(rst_n), .mode_check(drv_mode[1]), .bus(if1), .byte_counter(bc1)
    );
    crc8_framer dut2 (
        .clk(clk), .reset(rst_n), .mode_check(drv_mode[2]), .bus(if2), .byte_counter(bc2)
    );

    assign if0.in_data = drv_data[0]; assign if0.in_valid = drv_valid[0];
    assign if0.out_ready = drv_ready[0];
    assign if1.in_data = drv_data[1]; assign if1.in_valid = drv_valid[1];
    assign if1.out_ready = drv_ready[1];
    assign if2.in_data = drv_data[2]; assign if2.in_valid = drv_valid[2];
    assign if2.out_ready = drv_ready[2];

    assign o_data[0] = if0.out_data; assign o_valid[0] = if0.out_valid;
    assign o_rdy[0] = if0.in_ready;  assign o_crc[0] = if0.out_crc; assign o_err[0] = if0.crc_err;
    assign o_data[1] = if1.out_data; assign o_valid[1] = if1.out_valid;
    assign o_rdy[1] = if1.in_ready;  assign o_crc[1] = if1.out_crc; assign o_err[1] = if1.crc_err;
    assign o_data[2] = if2.out_data; assign o_valid[2] = if2.out_valid;
    assign o_rdy[2] = if2.in_ready;  assign o_crc[2] = if2.out_crc; assign o_err[2] = if2.crc_err;
    assign o_bc[0] = {4'b0000, bc0};
    assign o_bc[1] = {6'b000000, bc1};
    assign o_bc[2] = {4'b0000, bc2};

    logic [7:0] bp_in  [$];
    logic [7:0] bp_exp [$];
    logic       bp_crc [$];

    // Bit-serial reference, poly 0x07, MSB first.
    function automatic logic [7:0] model_crc(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; offers one byte and checks the registered result.
    task automatic beat(input int k, input logic [7:0] d, input logic [7:0] exp_out,
                        input logic exp_crc, input logic exp_err, input logic [7:0] exp_bc,
                        input string tag);
        drv_valid[k] = 1'b1;
        drv_data[k]  = d;
        #1;
        chk1({tag, ".in_ready"}, o_rdy[k], 1'b1);
        chk8({tag, ".bc"}, o_bc[k], exp_bc);
        @(posedge clk);
        @(negedge clk);
        drv_valid[k] = 1'b0;
        #1;
        chk1({tag, ".valid"}, o_valid[k], 1'b1);
        chk8({tag, ".data"}, o_data[k], exp_out);
        chk1({tag, ".crc"}, o_crc[k], exp_crc);
        chk1({tag, ".err"}, o_err[k], exp_err);
    endtask

    task automatic crc_beat(input int k, input logic [7:0] exp_out, input logic [7:0] exp_bc,
                            input string tag);
        drv_valid[k] = 1'b0;
        #1;
        chk1({tag, ".in_ready"}, o_rdy[k], 1'b0);
        chk8({tag, ".bc"}, o_bc[k], exp_bc);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk1({tag, ".valid"}, o_valid[k], 1'b1);
        chk8({tag, ".data"}, o_data[k], exp_out);
        chk1({tag, ".crc"}, o_crc[k], 1'b1);
        chk1({tag, ".err"}, o_err[k], 1'b0);
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] held;
        logic       stalled;
        int         ip;
        int         op;

        for (int k = 0; k < 3; k++) begin
            drv_data[k] = 8'h00; drv_valid[k] = 1'b0; drv_ready[k] = 1'b1; drv_mode[k] = 1'b0;
        end

        // Reset values
        #12;
        for (int k = 0; k < 3; k++) begin
            chk1("rst.valid", o_valid[k], 1'b0);
            chk8("rst.data", o_data[k], 8'h00);
            chk1("rst.crc", o_crc[k], 1'b0);
            chk1("rst.err", o_err[k], 1'b0);
            chk8("rst.bc", o_bc[k], 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference string "123456789", CRC 0xF4
        for (int i = 0; i < 9; i++) begin
            beat(0, 8'h31 + 8'(i), 8'h31 + 8'(i), 1'b0, 1'b0, 8'(i), "t1.pay");
        end
        crc_beat(0, 8'hF4, 8'd9, "t1.crc");
        chk8("t1.wrap", o_bc[0], 8'd0);

        // Short frames, generate mode
        beat(1, 8'h01, 8'h01, 1'b0, 1'b0, 8'd0, "t2.b01");
        crc_beat(1, 8'h07, 8'd1, "t2.c07");
        beat(1, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'd2, "t2.gAA");
        beat(1, 8'h80, 8'h80, 1'b0, 1'b0, 8'd0, "t2.b80");
        crc_beat(1, 8'h89, 8'd1, "t2.c89");
        beat(1, 8'h55, 8'h55, 1'b0, 1'b0, 8'd2, "t2.g55");
        chk8("t2.wrap", o_bc[1], 8'd0);

        // Short frames, check mode: good CRC then bad CRC
        drv_mode[1] = 1'b1;
        beat(1, 8'h01, 8'h01, 1'b0, 1'b0, 8'd0, "t3.b01");
        beat(1, 8'h07, 8'h07, 1'b1, 1'b0, 8'd1, "t3.c07");
        beat(1, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'd2, "t3.gAA");
        beat(1, 8'h80, 8'h80, 1'b0, 1'b0, 8'd0, "t3.b80");
        beat(1, 8'h88, 8'h88, 1'b1, 1'b1, 8'd1, "t3.c88");
        beat(1, 8'h55, 8'h55, 1'b0, 1'b0, 8'd2, "t3.g55");

        // Backpressure on default parameters: two frames under random valid/ready
        for (int f = 0; f < 2; f++) begin
            c = 8'hFF;
            for (int i = 0; i < 8; i++) begin
                bp_in.push_back(8'(f * 37 + i * 13 + 5));
                bp_exp.push_back(8'(f * 37 + i * 13 + 5));
                bp_crc.push_back(1'b0);
                c = model_crc(c, 8'(f * 37 + i * 13 + 5));
            end
            bp_exp.push_back(c);
            bp_crc.push_back(1'b1);
            bp_in.push_back(8'hC0 + 8'(f));
            bp_exp.push_back(8'hC0 + 8'(f));
            bp_crc.push_back(1'b0);
        end
        ip = 0;
        op = 0;
        stalled = 1'b0;
        held = 8'h00;
        for (int cyc = 0; cyc < 2000 && op < 20; cyc++) begin
            if (stalled) chk8("t4.hold", o_data[2], held);
            drv_valid[2] = (ip < 18) && ($urandom_range(0, 2) != 0);
            if (ip < 18) drv_data[2] = bp_in[ip];
            drv_ready[2] = ($urandom_range(0, 2) != 0);
            #1;
            if (o_valid[2] && drv_ready[2]) begin
                chk8("t4.data", o_data[2], bp_exp[op]);
                chk1("t4.crc", o_crc[2], bp_crc[op]);
                op++;
            end
            if (drv_valid[2] && o_rdy[2]) ip++;
            stalled = o_valid[2] && !drv_ready[2];
            held = o_data[2];
            @(posedge clk);
            @(negedge clk);
        end
        drv_valid[2] = 1'b0;
        drv_ready[2] = 1'b1;
        chk8("t4.beats", 8'(op), 8'd20);
        chk8("t4.inputs", 8'(ip), 8'd18);
        chk8("t4.bc", o_bc[2], 8'd0);

        // Reset after the fourth payload byte, then a fresh frame
        for (int i = 0; i < 4; i++) begin
            beat(2, 8'h11 * 8'(i + 1), 8'h11 * 8'(i + 1), 1'b0, 1'b0, 8'(i), "t5.pre");
        end
        rst_n = 1'b0;
        #1;
        chk1("t5.rst.valid", o_valid[2], 1'b0);
        chk8("t5.rst.data", o_data[2], 8'h00);
        chk1("t5.rst.crc", o_crc[2], 1'b0);
        chk8("t5.rst.bc", o_bc[2], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            beat(2, 8'hA0 + 8'(i), 8'hA0 + 8'(i), 1'b0, 1'b0, 8'(i), "t5.pay");
            c = model_crc(c, 8'hA0 + 8'(i));
        end
        crc_beat(2, c, 8'd8, "t5.crc");
        beat(2, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'd9, "t5.gap");
        chk8("t5.wrap", o_bc[2], 8'd0);

        // Mode change mid-frame takes effect only on the next frame
        c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drv_mode[2] = 1'b1;
            beat(2, 8'h30 + 8'(i), 8'h30 + 8'(i), 1'b0, 1'b0, 8'(i), "t6.payA");
            c = model_crc(c, 8'h30 + 8'(i));
        end
        crc_beat(2, c, 8'd8, "t6.crcA");
        beat(2, 8'h77, 8'h77, 1'b0, 1'b0, 8'd9, "t6.gapA");
        c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            beat(2, 8'h40 + 8'(i), 8'h40 + 8'(i), 1'b0, 1'b0, 8'(i), "t6.payB");
            c = model_crc(c, 8'h40 + 8'(i));
        end
        beat(2, c, c, 1'b1, 1'b0, 8'd8, "t6.crcB");
        beat(2, 8'h66, 8'h66, 1'b0, 1'b0, 8'd9, "t6.gapB");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
